cluster_sequencer: RTL

Parametrised load/compute/write-back sequencer for a PE cluster of NUM_PE_X columns by NUM_PE_Y rows. It drives the weight and activation multicast tag targets, the buffer read addresses, the compute start pulse, the partial-sum trigger and the output write address for one or more activation passes. Weights are loaded once per job. It sits between the global buffers and the PE array and replaces tag generation from the testbench.

---
 rtl/cluster_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cluster_sequencer.sv
// cluster_sequencer
//   Load/compute/write-back sequencer for a NUM_PE_X x NUM_PE_Y PE cluster.
//   Streams weights once per job, then for each pass streams activations,
//   pulses compute start, triggers partial sums and forwards output writes.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   start_i, cfg_*_i           job start and configuration (latched on start)
//   w_/a_rd_en_o, _rd_addr_o   buffer read strobes and addresses
//   w_/a_valid_o, *_tag_*_o    multicast valid and target tags
//   compute_start_o            one-cycle pulse to all PEs
//   pe_done_i, psum_valid_i    PE row done flags, top-row psum valid
//   trigger_sums_o             per-column partial-sum trigger
//   out_wr_en_o, out_wr_addr_o output write strobe and address
//   busy_o, done_o, err_o      status
//   perf_cycles_o              busy-cycle counter
// Optional feature: define CLUSTER_SEQ_PERF_EN to build the busy-cycle
// counter; otherwise perf_cycles_o is tied to zero.
module cluster_sequencer #(
  parameter int NUM_PE_X  = 3,
  parameter int NUM_PE_Y  = 3,
  parameter int ID_SIZE   = 8,
  parameter int ADDR_SIZE = 16,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start_i,
  input  logic [CNT_SIZE-1:0]  cfg_acount_i,
  input  logic [CNT_SIZE-1:0]  cfg_wcount_i,
  input  logic [CNT_SIZE-1:0]  cfg_passes_i,
  output logic                 w_rd_en_o,
  output logic                 a_rd_en_o,
  output logic [ADDR_SIZE-1:0] w_rd_addr_o,
  output logic [ADDR_SIZE-1:0] a_rd_addr_o,
  output logic                 w_valid_o,
  output logic                 a_valid_o,
  output logic [ID_SIZE-1:0]   w_tag_x_o,
  output logic [ID_SIZE-1:0]   w_tag_y_o,
  output logic [ID_SIZE-1:0]   a_tag_x_o,
  output logic [ID_SIZE-1:0]   a_tag_y_o,
  output logic                 compute_start_o,
  input  logic [NUM_PE_Y-1:0]  pe_done_i,
  output logic [NUM_PE_X-1:0]  trigger_sums_o,
  input  logic                 psum_valid_i,
  output logic                 out_wr_en_o,
  output logic [ADDR_SIZE-1:0] out_wr_addr_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          perf_cycles_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_A  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_PSUM    = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [CNT_SIZE-1:0]  cfg_a_q, cfg_a_d, cfg_w_q, cfg_w_d, cfg_p_q, cfg_p_d;
  logic [CNT_SIZE-1:0]  word_q, word_d, pass_q, pass_d;
  logic [ID_SIZE-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic [CNT_SIZE:0]    trig_cnt_q, trig_cnt_d;
  logic                 w_rd_en_q, w_rd_en_d, a_rd_en_q, a_rd_en_d;
  logic [ADDR_SIZE-1:0] w_rd_addr_q, w_rd_addr_d, a_rd_addr_q, a_rd_addr_d;
  logic                 w_valid_q, w_valid_d, a_valid_q, a_valid_d;
  logic [ID_SIZE-1:0]   w_tag_x_q, w_tag_x_d, w_tag_y_q, w_tag_y_d;
  logic [ID_SIZE-1:0]   a_tag_x_q, a_tag_x_d, a_tag_y_q, a_tag_y_d;
  logic                 compute_start_q, compute_start_d;
  logic [NUM_PE_X-1:0]  trigger_q, trigger_d;
  logic                 out_wr_en_q, out_wr_en_d;
  logic [ADDR_SIZE-1:0] out_wr_addr_q, out_wr_addr_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                 cfg_illegal, word_last, tx_last, ty_last, read_last;
  logic [CNT_SIZE-1:0]  word_lim;
  logic [CNT_SIZE:0]    trig_len;
  logic                 unused_pe_done;

  // Only the bottom and top row done flags steer the sequence.
  assign unused_pe_done = ^pe_done_i;

  assign cfg_illegal = (cfg_wcount_i == '0) || (cfg_acount_i < cfg_wcount_i) ||
                       (cfg_passes_i == '0);
  assign word_lim  = (state_q == S_LOAD_W) ? cfg_w_q : cfg_a_q;
  assign word_last = (word_q == word_lim - CNT_SIZE'(1));
  assign tx_last   = (tx_q == ID_SIZE'(NUM_PE_X - 1));
  assign ty_last   = (ty_q == ID_SIZE'(NUM_PE_Y - 1));
  assign read_last = word_last && tx_last && ty_last;
  assign trig_len  = {1'b0, cfg_a_q} - {1'b0, cfg_w_q} + (CNT_SIZE+1)'(1);

  always_comb begin
    state_d         = state_q;
    cfg_a_d         = cfg_a_q;
    cfg_w_d         = cfg_w_q;
    cfg_p_d         = cfg_p_q;
    word_d          = word_q;
    pass_d          = pass_q;
    tx_d            = tx_q;
    ty_d            = ty_q;
    trig_cnt_d      = trig_cnt_q;
    w_rd_en_d       = 1'b0;
    a_rd_en_d       = 1'b0;
    w_rd_addr_d     = w_rd_addr_q;
    a_rd_addr_d     = a_rd_addr_q;
    w_valid_d       = w_rd_en_q;
    a_valid_d       = a_rd_en_q;
    w_tag_x_d       = w_tag_x_q;
    w_tag_y_d       = w_tag_y_q;
    a_tag_x_d       = a_tag_x_q;
    a_tag_y_d       = a_tag_y_q;
    compute_start_d = 1'b0;
    trigger_d       = '0;
    out_wr_en_d     = psum_valid_i;
    out_wr_addr_d   = out_wr_en_q ? out_wr_addr_q + ADDR_SIZE'(1) : out_wr_addr_q;
    err_d           = err_q;

    // Tags ride one stage behind the read so they line up with valid.
    if (w_rd_en_q) begin
      w_tag_x_d = tx_q;
      w_tag_y_d = ty_q;
    end
    if (a_rd_en_q) begin
      a_tag_x_d = tx_q;
      a_tag_y_d = ty_q;
    end

    // Shared word/PE walk for both streams; wraps to zero after the last read.
    if (w_rd_en_q || a_rd_en_q) begin
      if (word_last) begin
        word_d = '0;
        if (tx_last) begin
          tx_d = '0;
          ty_d = ty_last ? '0 : ty_q + ID_SIZE'(1);
        end else begin
          tx_d = tx_q + ID_SIZE'(1);
        end
      end else begin
        word_d = word_q + CNT_SIZE'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        w_rd_addr_d   = '0;
        a_rd_addr_d   = '0;
        out_wr_addr_d = '0;
        pass_d        = '0;
        word_d        = '0;
        tx_d          = '0;
        ty_d          = '0;
        if (start_i) begin
          cfg_a_d = cfg_acount_i;
          cfg_w_d = cfg_wcount_i;
          cfg_p_d = cfg_passes_i;
          err_d   = cfg_illegal;
          if (cfg_illegal) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_LOAD_W;
            w_rd_en_d = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        w_rd_addr_d = w_rd_addr_q + ADDR_SIZE'(1);
        if (read_last) begin
          state_d   = S_LOAD_A;
          a_rd_en_d = 1'b1;
        end else begin
          w_rd_en_d = 1'b1;
        end
      end
      S_LOAD_A: begin
        // A cycle without a read is the drain cycle for the final a_valid.
        if (a_rd_en_q) begin
          a_rd_addr_d = a_rd_addr_q + ADDR_SIZE'(1);
          a_rd_en_d   = !read_last;
        end else begin
          state_d         = S_COMPUTE;
          compute_start_d = 1'b1;
        end
      end
      S_COMPUTE: begin
        if (pe_done_i[0]) begin
          state_d    = S_PSUM;
          trigger_d  = '1;
          trig_cnt_d = (CNT_SIZE+1)'(1);
        end
      end
      S_PSUM: begin
        if (trigger_q[0]) begin
          if (trig_cnt_q != trig_len) begin
            trigger_d  = '1;
            trig_cnt_d = trig_cnt_q + (CNT_SIZE+1)'(1);
          end
        end else if (pe_done_i[NUM_PE_Y-1]) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        pass_d = pass_q + CNT_SIZE'(1);
        if (({1'b0, pass_q} + (CNT_SIZE+1)'(1)) == {1'b0, cfg_p_q}) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_LOAD_A;
          a_rd_en_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= S_IDLE;
      cfg_a_q         <= '0;
      cfg_w_q         <= '0;
      cfg_p_q         <= '0;
      word_q          <= '0;
      pass_q          <= '0;
      tx_q            <= '0;
      ty_q            <= '0;
      trig_cnt_q      <= '0;
      w_rd_en_q       <= 1'b0;
      a_rd_en_q       <= 1'b0;
      w_rd_addr_q     <= '0;
      a_rd_addr_q     <= '0;
      w_valid_q       <= 1'b0;
      a_valid_q       <= 1'b0;
      w_tag_x_q       <= '0;
      w_tag_y_q       <= '0;
      a_tag_x_q       <= '0;
      a_tag_y_q       <= '0;
      compute_start_q <= 1'b0;
      trigger_q       <= '0;
      out_wr_en_q     <= 1'b0;
      out_wr_addr_q   <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cfg_a_q         <= cfg_a_d;
      cfg_w_q         <= cfg_w_d;
      cfg_p_q         <= cfg_p_d;
      word_q          <= word_d;
      pass_q          <= pass_d;
      tx_q            <= tx_d;
      ty_q            <= ty_d;
      trig_cnt_q      <= trig_cnt_d;
      w_rd_en_q       <= w_rd_en_d;
      a_rd_en_q       <= a_rd_en_d;
      w_rd_addr_q     <= w_rd_addr_d;
      a_rd_addr_q     <= a_rd_addr_d;
      w_valid_q       <= w_valid_d;
      a_valid_q       <= a_valid_d;
      w_tag_x_q       <= w_tag_x_d;
      w_tag_y_q       <= w_tag_y_d;
      a_tag_x_q       <= a_tag_x_d;
      a_tag_y_q       <= a_tag_y_d;
      compute_start_q <= compute_start_d;
      trigger_q       <= trigger_d;
      out_wr_en_q     <= out_wr_en_d;
      out_wr_addr_q   <= out_wr_addr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

`ifdef CLUSTER_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start_i) begin
      perf_d = '0;
    end else if (busy_q && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

  assign w_rd_en_o       = w_rd_en_q;
  assign a_rd_en_o       = a_rd_en_q;
  assign w_rd_addr_o     = w_rd_addr_q;
  assign a_rd_addr_o     = a_rd_addr_q;
  assign w_valid_o       = w_valid_q;
  assign a_valid_o       = a_valid_q;
  assign w_tag_x_o       = w_tag_x_q;
  assign w_tag_y_o       = w_tag_y_q;
  assign a_tag_x_o       = a_tag_x_q;
  assign a_tag_y_o       = a_tag_y_q;
  assign compute_start_o = compute_start_q;
  assign trigger_sums_o  = trigger_q;
  assign out_wr_en_o     = out_wr_en_q;
  assign out_wr_addr_o   = out_wr_addr_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
